// File: rtl/periph_avmm_host.sv
// periph_avmm_host
//   Bridges a simple valid/ready command/response pair onto an Avalon-MM host
//   port. At most one transaction is in flight at a time.
//
//   Parameters
//     TIMEOUT_CYCLES  cycles allowed per transaction before abort (>= 2)
//     ADDR_W          Avalon-MM byte-address width
//
//   Ports
//     clk_clk, reset_reset            clock, synchronous active-high reset
//     cmd_valid/ready/write/address/writedata/byteenable   command channel
//     rsp_valid/ready/readdata/error                       response channel
//     m_address/writedata/byteenable/read/write            Avalon-MM request
//     m_burstcount (=1), m_debugaccess (=0)                Avalon-MM constants
//     m_waitrequest/readdatavalid/readdata                 Avalon-MM returns
//
//   Build option
//     PERIPH_AVMM_HOST_TIMEOUT_EN  compiles in the per-transaction timeout.
//     Without it, REQ/RDWAIT wait indefinitely and rsp_error is tied low.
module periph_avmm_host #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned ADDR_W         = 24
) (
  input  logic              clk_clk,
  input  logic              reset_reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_address,
  input  logic [31:0]       cmd_writedata,
  input  logic [3:0]        cmd_byteenable,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_readdata,
  output logic              rsp_error,
  output logic [ADDR_W-1:0] m_address,
  output logic [31:0]       m_writedata,
  output logic [3:0]        m_byteenable,
  output logic              m_read,
  output logic              m_write,
  output logic              m_burstcount,
  output logic              m_debugaccess,
  input  logic              m_waitrequest,
  input  logic              m_readdatavalid,
  input  logic [31:0]       m_readdata
);

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("periph_avmm_host: TIMEOUT_CYCLES must be >= 2");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    RDWAIT = 2'd2,
    RSP    = 2'd3
  } state_t;

  state_t state;
  state_t state_nxt;

  logic cap_write;     // direction of the transaction in flight
  logic req_accepted;  // responder took the request this cycle
  logic rd_returned;   // read data arrives this cycle
  logic timeout_hit;   // transaction budget exhausted this cycle

  assign req_accepted = (state == REQ) && !m_waitrequest;
  // readdatavalid is only meaningful while waiting for it
  assign rd_returned  = (state == RDWAIT) && m_readdatavalid;

`ifdef PERIPH_AVMM_HOST_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] to_cnt;
  logic             rsp_error_q;

  // Counter is 0 in the first REQ cycle, so the hit fires on the
  // TIMEOUT_CYCLES-th cycle spent in REQ/RDWAIT.
  assign timeout_hit = ((state == REQ) || (state == RDWAIT)) &&
                       (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      to_cnt <= '0;
    end else if ((state != REQ) && (state_nxt == REQ)) begin
      to_cnt <= '0;
    end else if ((state == REQ) || (state == RDWAIT)) begin
      to_cnt <= to_cnt + CNT_W'(1);
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // State register
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; a completing handshake wins over a coincident timeout
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (cmd_valid) state_nxt = REQ;
      end
      REQ: begin
        if (req_accepted)     state_nxt = cap_write ? RSP : RDWAIT;
        else if (timeout_hit) state_nxt = RSP;
      end
      RDWAIT: begin
        if (rd_returned || timeout_hit) state_nxt = RSP;
      end
      RSP: begin
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Command capture and response data registers
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      cap_write    <= 1'b0;
      m_address    <= '0;
      m_writedata  <= '0;
      m_byteenable <= '0;
      rsp_readdata <= '0;
`ifdef PERIPH_AVMM_HOST_TIMEOUT_EN
      rsp_error_q  <= 1'b0;
`endif
    end else begin
      if ((state == IDLE) && cmd_valid) begin
        cap_write    <= cmd_write;
        m_address    <= cmd_address;
        m_writedata  <= cmd_writedata;
        m_byteenable <= cmd_byteenable;
      end
      if (req_accepted && cap_write) begin
        rsp_readdata <= '0;
`ifdef PERIPH_AVMM_HOST_TIMEOUT_EN
        rsp_error_q  <= 1'b0;
`endif
      end else if (rd_returned) begin
        rsp_readdata <= m_readdata;
`ifdef PERIPH_AVMM_HOST_TIMEOUT_EN
        rsp_error_q  <= 1'b0;
      end else if (timeout_hit && !req_accepted) begin
        rsp_readdata <= 32'hDEAD_BEEF;
        rsp_error_q  <= 1'b1;
`endif
      end
    end
  end

  // Outputs
  always_comb begin
    cmd_ready     = (state == IDLE);
    rsp_valid     = (state == RSP);
    m_write       = (state == REQ) && cap_write;
    m_read        = (state == REQ) && !cap_write;
    m_burstcount  = 1'b1;
    m_debugaccess = 1'b0;
`ifdef PERIPH_AVMM_HOST_TIMEOUT_EN
    rsp_error     = rsp_error_q;
`else
    rsp_error     = 1'b0;
`endif
  end

endmodule

// File: tb/tb_periph_avmm_host.sv
module tb_periph_avmm_host;

  localparam int unsigned ADDR_W = 24;

  logic              clk_clk = 1'b0;
  logic              reset_reset;
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_address;
  logic [31:0]       cmd_writedata;
  logic [3:0]        cmd_byteenable;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_readdata;
  logic              rsp_error;
  logic [ADDR_W-1:0] m_address;
  logic [31:0]       m_writedata;
  logic [3:0]        m_byteenable;
  logic              m_read;
  logic              m_write;
  logic              m_burstcount;
  logic              m_debugaccess;
  logic              m_waitrequest;
  logic              m_readdatavalid;
  logic [31:0]       m_readdata;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  periph_avmm_host #(
    .TIMEOUT_CYCLES(8),
    .ADDR_W        (ADDR_W)
  ) dut (
    .clk_clk        (clk_clk),
    .reset_reset    (reset_reset),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_write      (cmd_write),
    .cmd_address    (cmd_address),
    .cmd_writedata  (cmd_writedata),
    .cmd_byteenable (cmd_byteenable),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_readdata   (rsp_readdata),
    .rsp_error      (rsp_error),
    .m_address      (m_address),
    .m_writedata    (m_writedata),
    .m_byteenable   (m_byteenable),
    .m_read         (m_read),
    .m_write        (m_write),
    .m_burstcount   (m_burstcount),
    .m_debugaccess  (m_debugaccess),
    .m_waitrequest  (m_waitrequest),
    .m_readdatavalid(m_readdatavalid),
    .m_readdata     (m_readdata)
  );

  always #5 clk_clk = ~clk_clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk_clk);
    #1;
  endtask

  // Offer a command for exactly one cycle (DUT must be in IDLE)
  task automatic issue(input logic wr, input logic [ADDR_W-1:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be);
    check("cmd_ready_idle", {31'd0, cmd_ready}, 32'd1);
    cmd_valid      = 1'b1;
    cmd_write      = wr;
    cmd_address    = addr;
    cmd_writedata  = wdata;
    cmd_byteenable = be;
    tick;
    cmd_valid      = 1'b0;
  endtask

  task automatic push_exp(input logic [31:0] d, input logic e);
    exp_t x;
    x.data = d;
    x.err  = e;
    sb.push_back(x);
  endtask

  // Bounded wait for rsp_valid; an expired bound counts as a failure
  task automatic wait_rsp(input string tag, input int max_cycles);
    int n = 0;
    while (!rsp_valid && n < max_cycles) begin
      tick;
      n++;
    end
    check(tag, {31'd0, rsp_valid}, 32'd1);
  endtask

  // Response scoreboard: every handshake pops one expectation
  always @(negedge clk_clk) begin
    if (!reset_reset && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        check("sb_unexpected_rsp", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_rsp_readdata", rsp_readdata, e.data);
        check("sb_rsp_error", {31'd0, rsp_error}, {31'd0, e.err});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_reset     = 1'b1;
    cmd_valid       = 1'b0;
    cmd_write       = 1'b0;
    cmd_address     = '0;
    cmd_writedata   = '0;
    cmd_byteenable  = '0;
    rsp_ready       = 1'b1;
    m_waitrequest   = 1'b0;
    m_readdatavalid = 1'b0;
    m_readdata      = '0;

    repeat (3) tick;
    reset_reset = 1'b0;
    tick;

    // Reset values
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp_readdata", rsp_readdata, 32'd0);
    check("rst_rsp_error", {31'd0, rsp_error}, 32'd0);
    check("rst_m_rdwr", {30'd0, m_read, m_write}, 32'd0);
    check("rst_m_address", {8'd0, m_address}, 32'd0);
    check("rst_m_writedata", m_writedata, 32'd0);
    check("rst_m_byteenable", {28'd0, m_byteenable}, 32'd0);
    check("const_burst_debug", {30'd0, m_burstcount, m_debugaccess}, 32'd2);

    // Write, waitrequest low: one-cycle strobe, rsp_valid two cycles after accept
    push_exp(32'd0, 1'b0);
    issue(1'b1, 24'h000010, 32'hA5A5_5A5A, 4'hF);
    check("wr_m_write", {30'd0, m_read, m_write}, 32'd1);
    check("wr_m_address", {8'd0, m_address}, 32'h10);
    check("wr_m_writedata", m_writedata, 32'hA5A5_5A5A);
    check("wr_m_byteenable", {28'd0, m_byteenable}, 32'hF);
    check("wr_cmd_ready_busy", {31'd0, cmd_ready}, 32'd0);
    check("wr_rsp_not_yet", {31'd0, rsp_valid}, 32'd0);
    tick;
    check("wr_strobe_drop", {30'd0, m_read, m_write}, 32'd0);
    check("wr_rsp_latency", {31'd0, rsp_valid}, 32'd1);
    tick;
    check("wr_back_idle", {30'd0, cmd_ready, rsp_valid}, 32'd2);

    // Read with three waitrequest cycles: request held four cycles
    push_exp(32'h1234_5678, 1'b0);
    m_waitrequest = 1'b1;
    issue(1'b0, 24'h000020, 32'h0, 4'hF);
    for (int i = 0; i < 4; i++) begin
      check("rd_m_read_held", {30'd0, m_read, m_write}, 32'd2);
      check("rd_m_address_held", {8'd0, m_address}, 32'h20);
      m_waitrequest = (i < 3);
      tick;
    end
    check("rd_strobe_drop", {30'd0, m_read, m_write}, 32'd0);
    check("rd_rdwait_no_rsp", {31'd0, rsp_valid}, 32'd0);
    m_readdatavalid = 1'b1;
    m_readdata      = 32'h1234_5678;
    tick;
    m_readdatavalid = 1'b0;
    m_readdata      = 32'h0;
    check("rd_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check("rd_rsp_readdata", rsp_readdata, 32'h1234_5678);
    tick;

    // Response back-pressure: response held, new commands ignored
    push_exp(32'hCAFE_F00D, 1'b0);
    rsp_ready = 1'b0;
    issue(1'b0, 24'h000044, 32'h0, 4'h3);
    tick;
    m_readdatavalid = 1'b1;
    m_readdata      = 32'hCAFE_F00D;
    tick;
    m_readdatavalid = 1'b0;
    m_readdata      = 32'h0;
    for (int i = 0; i < 5; i++) begin
      check("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      check("bp_rsp_readdata", rsp_readdata, 32'hCAFE_F00D);
      check("bp_cmd_ready", {31'd0, cmd_ready}, 32'd0);
      check("bp_no_request", {30'd0, m_read, m_write}, 32'd0);
      cmd_valid   = 1'b1;
      cmd_write   = 1'b1;
      cmd_address = 24'h000099;
      tick;
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    tick;
    check("bp_back_idle", {30'd0, cmd_ready, rsp_valid}, 32'd2);
    tick;
    check("bp_ignored_cmd", {30'd0, m_read, m_write}, 32'd0);

    // Reset in RDWAIT aborts without a response
    issue(1'b0, 24'h000055, 32'h0, 4'hC);
    tick;
    check("rst_mid_m_address_pre", {8'd0, m_address}, 32'h55);
    reset_reset = 1'b1;
    tick;
    reset_reset = 1'b0;
    check("rst_mid_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("rst_mid_rsp", {30'd0, rsp_valid, rsp_error}, 32'd0);
    check("rst_mid_rsp_readdata", rsp_readdata, 32'd0);
    check("rst_mid_m_rdwr", {30'd0, m_read, m_write}, 32'd0);
    check("rst_mid_m_address", {8'd0, m_address}, 32'd0);
    check("rst_mid_m_be", {28'd0, m_byteenable}, 32'd0);
    m_readdatavalid = 1'b1;
    m_readdata      = 32'h7777_7777;
    tick;
    m_readdatavalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("rst_mid_no_rsp", {31'd0, rsp_valid}, 32'd0);
      tick;
    end

    // Spurious readdatavalid during a write request is ignored
    push_exp(32'd0, 1'b0);
    m_waitrequest = 1'b1;
    issue(1'b1, 24'h000030, 32'h0F0F_0F0F, 4'h5);
    m_readdatavalid = 1'b1;
    m_readdata      = 32'hFFFF_FFFF;
    tick;
    m_waitrequest = 1'b0;
    tick;
    m_readdatavalid = 1'b0;
    m_readdata      = 32'h0;
    check("spur_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check("spur_rsp_readdata", rsp_readdata, 32'd0);
    tick;

`ifdef PERIPH_AVMM_HOST_TIMEOUT_EN
    // Unanswered read times out; a late readdatavalid produces nothing
    push_exp(32'hDEAD_BEEF, 1'b1);
    rsp_ready = 1'b0;
    issue(1'b0, 24'h000060, 32'h0, 4'hF);
    wait_rsp("to_rsp_wait", 40);
    check("to_rsp_error", {31'd0, rsp_error}, 32'd1);
    check("to_rsp_readdata", rsp_readdata, 32'hDEAD_BEEF);
    check("to_strobes_low", {30'd0, m_read, m_write}, 32'd0);
    rsp_ready = 1'b1;
    tick;
    m_readdatavalid = 1'b1;
    m_readdata      = 32'h5555_AAAA;
    tick;
    m_readdatavalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("to_late_no_rsp", {31'd0, rsp_valid}, 32'd0);
      tick;
    end
`else
    // No timeout logic: a slow read still completes cleanly
    push_exp(32'h0BAD_F00D, 1'b0);
    issue(1'b0, 24'h000060, 32'h0, 4'hF);
    repeat (20) tick;
    check("slow_still_waiting", {31'd0, rsp_valid}, 32'd0);
    m_readdatavalid = 1'b1;
    m_readdata      = 32'h0BAD_F00D;
    tick;
    m_readdatavalid = 1'b0;
    m_readdata      = 32'h0;
    wait_rsp("slow_rsp_wait", 4);
    check("slow_rsp_error", {31'd0, rsp_error}, 32'd0);
    tick;
`endif

    repeat (2) tick;
    check("sb_drained", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
